// File: rtl/tx_frame_sequencer_if.sv
// Handshake bundle between the TX async FIFO read port, the frame sequencer and the GMII pins.
// The master modport is the sequencer side; the slave modport is the FIFO/PHY environment.
interface tx_frame_sequencer_if;
  logic        start;
  logic [10:0] payload_len;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_r_en;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        len_err;

  modport master (
    input  start, payload_len, fifo_empty, fifo_data,
    output fifo_r_en, gmii_txd, gmii_tx_en, gmii_tx_er, busy, done, underrun, len_err
  );

  modport slave (
    output start, payload_len, fifo_empty, fifo_data,
    input  fifo_r_en, gmii_txd, gmii_tx_en, gmii_tx_er, busy, done, underrun, len_err
  );
endinterface

// File: rtl/tx_frame_sequencer.sv
// GMII transmit sequencer: preamble/SFD, MAC header, length, FIFO payload, pad, FCS, inter-frame gap.
// Define TX_FCS_EN to build the CRC-32 generator and append the 4-byte FCS; otherwise no FCS is sent.
module tx_frame_sequencer #(
  parameter logic [47:0] DST_MAC     = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC     = 48'h023528fbdd66,
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic                 eth_tx_clk,
  input  logic                 eth_rst,
  tx_frame_sequencer_if.master tx
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DST,
    S_SRC,
    S_LEN,
    S_PAY,
    S_PAD,
    S_FCS,
    S_ERR,
    S_IFG
  } state_t;

  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  state_t      post_data;
  logic [10:0] cnt_q;
  logic [10:0] len_q;
  logic        clean_q;
  logic        len_err_q;
  logic [10:0] last_cnt;
  logic        last;
  logic        pad_needed;
  logic        read_req;
  logic        len_ok;

`ifdef TX_FCS_EN
  logic [31:0] crc_q;
  logic        crc_en;
`endif

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

`ifdef TX_FCS_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    len_ok     = (tx.payload_len != 11'd0) && (tx.payload_len <= MAX_LEN);
    pad_needed = (len_q < MIN_LEN);
`ifdef TX_FCS_EN
    post_data  = S_FCS;
`else
    post_data  = S_IFG;
`endif
  end

  // Terminal count of the shared byte counter for the current state
  always_comb begin
    last_cnt = '0;
    case (state_q)
      S_PRE:        last_cnt = 11'd6;
      S_DST, S_SRC: last_cnt = 11'd5;
      S_LEN:        last_cnt = 11'd1;
      S_PAY:        last_cnt = len_q - 11'd1;
      S_PAD:        last_cnt = MIN_LEN - len_q - 11'd1;
      S_FCS:        last_cnt = 11'd3;
      S_IFG:        last_cnt = IFG_LAST;
      default:      last_cnt = '0;
    endcase
    last = (cnt_q == last_cnt);
  end

  // Prefetch one byte ahead so fifo_data is valid in the PAY cycle that drives it
  always_comb begin
    read_req = ((state_q == S_LEN) && last) || ((state_q == S_PAY) && !last);
  end

  always_comb begin
    state_d       = state_q;
    tx.fifo_r_en  = read_req && !tx.fifo_empty;
    tx.gmii_txd   = '0;
    tx.gmii_tx_en = 1'b0;
    tx.gmii_tx_er = 1'b0;
    tx.underrun   = 1'b0;
    tx.done       = 1'b0;
    tx.busy       = (state_q != S_IDLE);
    tx.len_err    = len_err_q;

    case (state_q)
      S_IDLE: begin
        if (tx.start && len_ok) state_d = S_PRE;
      end
      S_PRE: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = 8'h55;
        if (last) state_d = S_SFD;
      end
      S_SFD: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = 8'hD5;
        state_d       = S_DST;
      end
      S_DST: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = mac_byte(DST_MAC, cnt_q[2:0]);
        if (last) state_d = S_SRC;
      end
      S_SRC: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = mac_byte(SRC_MAC, cnt_q[2:0]);
        if (last) state_d = S_LEN;
      end
      S_LEN: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = (cnt_q == 11'd0) ? {5'b0, len_q[10:8]} : len_q[7:0];
        if (last) state_d = tx.fifo_empty ? S_ERR : S_PAY;
      end
      S_PAY: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = tx.fifo_data;
        if (last) begin
          state_d = pad_needed ? S_PAD : post_data;
        end else if (tx.fifo_empty) begin
          state_d = S_ERR;
        end
      end
      S_PAD: begin
        tx.gmii_tx_en = 1'b1;
        if (last) state_d = post_data;
      end
`ifdef TX_FCS_EN
      S_FCS: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_txd   = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
        if (last) state_d = S_IFG;
      end
`endif
      S_ERR: begin
        tx.gmii_tx_en = 1'b1;
        tx.gmii_tx_er = 1'b1;
        tx.underrun   = 1'b1;
        state_d       = S_IFG;
      end
      S_IFG: begin
        tx.done = clean_q && (cnt_q == 11'd0);
        if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge eth_tx_clk) begin
    if (eth_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      clean_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 11'd1;
      len_err_q <= (state_q == S_IDLE) && tx.start && !len_ok;
      if ((state_q == S_IDLE) && tx.start && len_ok) len_q <= tx.payload_len;
      // Remember on IFG entry whether the frame ended through the underrun path
      if ((state_d == S_IFG) && (state_q != S_IFG)) clean_q <= (state_q != S_ERR);
    end
  end

`ifdef TX_FCS_EN
  always_comb begin
    crc_en = (state_q == S_DST) || (state_q == S_SRC) || (state_q == S_LEN) ||
             (state_q == S_PAY) || (state_q == S_PAD);
  end

  always_ff @(posedge eth_tx_clk) begin
    if (eth_rst || (state_q == S_IDLE)) begin
      crc_q <= '1;
    end else if (crc_en) begin
      crc_q <= crc_byte(crc_q, tx.gmii_txd);
    end
  end
`endif

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: full frame, padded frame, underrun, length rejection,
// maximum length and mid-frame reset, each against a byte-level expected frame built here.
module tb_tx_frame_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef TX_FCS_EN
  localparam int unsigned FCS_N = 4;
`else
  localparam int unsigned FCS_N = 0;
`endif

  tx_frame_sequencer_if ifc ();

  tx_frame_sequencer #(
    .DST_MAC    (48'h023528fbdd66),
    .SRC_MAC    (48'h023528fbdd66),
    .IFG_CYCLES (12),
    .MIN_PAYLOAD(46),
    .MAX_PAYLOAD(1500)
  ) dut (
    .eth_tx_clk(clk),
    .eth_rst   (rst),
    .tx        (ifc)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // FIFO model: one-cycle read latency
  logic [7:0]  mem [0:4095];
  int unsigned wr_ptr   = 0;
  int unsigned rd_ptr   = 0;
  int unsigned rd_count = 0;
  assign ifc.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (ifc.fifo_r_en) begin
      ifc.fifo_data <= mem[rd_ptr % 4096];
      rd_ptr        <= rd_ptr + 1;
      rd_count      <= rd_count + 1;
    end
  end

  // Wire monitor
  logic [7:0]  cap [0:4095];
  int unsigned cap_n = 0, er_cycles = 0, ifg_cycles = 0, done_n = 0, under_n = 0, lenerr_n = 0;
  always @(negedge clk) begin
    if (ifc.gmii_tx_en) begin
      cap[cap_n % 4096] <= ifc.gmii_txd;
      cap_n             <= cap_n + 1;
    end
    if (ifc.gmii_tx_er)                 er_cycles  <= er_cycles + 1;
    if (ifc.busy && !ifc.gmii_tx_en)    ifg_cycles <= ifg_cycles + 1;
    if (ifc.done)                       done_n     <= done_n + 1;
    if (ifc.underrun)                   under_n    <= under_n + 1;
    if (ifc.len_err)                    lenerr_n   <= lenerr_n + 1;
  end

  logic [14:0] outs;
  always_comb outs = {ifc.gmii_txd, ifc.gmii_tx_en, ifc.gmii_tx_er, ifc.fifo_r_en,
                      ifc.busy, ifc.done, ifc.underrun, ifc.len_err};

  logic [7:0]  exp_b [0:4095];
  int unsigned exp_n;
  int unsigned nz;
  int unsigned s_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    exp_b[exp_n % 4096] = b;
    exp_n++;
  endtask

`ifdef TX_FCS_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  task automatic build_expected(input int unsigned len, input int unsigned base, input int unsigned avail);
    logic [47:0] mac;
    logic [15:0] lv;
    int unsigned npay;
`ifdef TX_FCS_EN
    logic [31:0] crc;
`endif
    mac   = 48'h023528fbdd66;
    lv    = 16'(len);
    npay  = (avail < len) ? avail : len;
    exp_n = 0;
    for (int i = 0; i < 7; i++) push(8'h55);
    push(8'hD5);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) push(mac[47 - 8*i -: 8]);
    push(lv[15:8]);
    push(lv[7:0]);
    for (int unsigned i = 0; i < npay; i++) push(mem[(base + i) % 4096]);
    if (avail < len) begin
      push(8'h00);
      return;
    end
    for (int unsigned i = len; i < 46; i++) push(8'h00);
`ifdef TX_FCS_EN
    crc = 32'hFFFFFFFF;
    for (int unsigned i = 8; i < exp_n; i++) crc = crc_upd(crc, exp_b[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) push(crc[8*i +: 8]);
`endif
  endtask

  task automatic send_start(input int unsigned len);
    @(posedge clk); #1;
    ifc.start       = 1'b1;
    ifc.payload_len = 11'(len);
    @(posedge clk); #1;
    ifc.start       = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((ifc.busy !== 1'b0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle within budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic run_frame(input string tag, input int unsigned len, input int unsigned avail,
                           input logic [7:0] seed, input int unsigned wire_len,
                           input int unsigned exp_done, input int unsigned exp_under);
    int unsigned base, s_cap, s_er, s_ifg, s_done, s_und, s_rd, nbad;
    base   = wr_ptr;
    s_cap  = cap_n;   s_er  = er_cycles; s_ifg = ifg_cycles;
    s_done = done_n;  s_und = under_n;   s_rd  = rd_count;
    for (int unsigned i = 0; i < avail; i++) begin
      mem[wr_ptr % 4096] = seed + 8'(i);
      wr_ptr++;
    end
    build_expected(len, base, avail);
    send_start(len);
    @(negedge clk);
    chk({tag, " first PRE cycle"}, 32'({ifc.busy, ifc.gmii_tx_en, ifc.gmii_txd}), 32'({2'b11, 8'h55}));
    wait_idle(tag, 4000);
    chk({tag, " tx_en cycles"}, cap_n - s_cap, wire_len);
    nbad = 0;
    for (int unsigned i = 0; i < exp_n; i++)
      if (cap[(s_cap + i) % 4096] !== exp_b[i]) nbad++;
    chk({tag, " bad bytes"}, nbad, 0);
    chk({tag, " done pulses"}, done_n - s_done, exp_done);
    chk({tag, " underrun pulses"}, under_n - s_und, exp_under);
    chk({tag, " tx_er cycles"}, er_cycles - s_er, exp_under);
    chk({tag, " ifg cycles"}, ifg_cycles - s_ifg, 12);
    chk({tag, " fifo reads"}, rd_count - s_rd, (avail < len) ? avail : len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start       = 1'b0;
    ifc.payload_len = '0;
    rst             = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 32'(outs), 32'd0);
    #1 rst = 1'b0;

    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if (outs !== '0) nz++;
    end
    chk("idle nonzero cycles", nz, 0);
    chk("idle fifo reads", rd_count, 0);

    run_frame("len60", 60, 60, 8'h00, 82 + FCS_N, 1, 0);
    run_frame("len10", 10, 10, 8'hA0, 68 + FCS_N, 1, 0);
    run_frame("underrun", 20, 5, 8'h40, 28, 0, 1);

    s_len = lenerr_n;
    send_start(0);
    @(negedge clk);
    chk("len0 len_err/busy", 32'({ifc.len_err, ifc.busy}), 32'(2'b10));
    @(negedge clk);
    chk("len0 pulse width", 32'(ifc.len_err), 32'd0);
    send_start(1501);
    @(negedge clk);
    chk("len1501 len_err/busy", 32'({ifc.len_err, ifc.busy}), 32'(2'b10));
    @(negedge clk);
    chk("len_err pulses", lenerr_n - s_len, 2);

    run_frame("len1500", 1500, 1500, 8'h11, 1522 + FCS_N, 1, 0);

    for (int unsigned i = 0; i < 46; i++) begin
      mem[wr_ptr % 4096] = 8'h80 + 8'(i);
      wr_ptr++;
    end
    send_start(46);
    repeat (30) @(negedge clk);
    chk("mid-PAY tx_en", 32'(ifc.gmii_tx_en), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after reset en/busy", 32'({ifc.gmii_tx_en, ifc.busy}), 32'd0);
    wr_ptr = rd_ptr;

    run_frame("len46", 46, 46, 8'hC0, 68 + FCS_N, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
Transmit-side controller that sequences one Ethernet frame at a time onto the GMII byte interface in the eth_tx_clk domain. It emits preamble/SFD, the MAC header and the length field, pulls payload bytes from the read side of the TX async FIFO, pads short payloads, appends the FCS, and enforces the inter-frame gap. It sits between the async FIFO read port and the PHY-facing GMII outputs.

Parameters:
DST_MAC, 48'h023528fbdd66, destination MAC, sent MSB byte first
SRC_MAC, 48'h023528fbdd66, source MAC, sent MSB byte first
IFG_CYCLES, 12, idle cycles enforced after each frame (min 1)
MIN_PAYLOAD, 46, payload+pad floor in bytes
MAX_PAYLOAD, 1500, largest accepted payload_len

Ports:
eth_tx_clk  in  1  single clock; all logic rising-edge
eth_rst  in  1  synchronous, active-high reset
start  in  1  frame request, sampled only in IDLE
payload_len  in  11  payload byte count, latched with accepted start
fifo_empty  in  1  TX FIFO read-side empty
fifo_data  in  8  TX FIFO data_out, valid the cycle after fifo_r_en
fifo_r_en  out  1  TX FIFO read strobe
gmii_txd  out  8  transmit byte
gmii_tx_en  out  1  frame byte valid
gmii_tx_er  out  1  error marker
busy  out  1  high from start acceptance through end of IFG
done  out  1  1-cycle pulse, frame completed cleanly
underrun  out  1  1-cycle pulse, FIFO empty when a payload byte was required
len_err  out  1  1-cycle pulse, start rejected

Behaviour:
- Reset (eth_rst=1 at a clock edge): state IDLE. All outputs are 0: gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, fifo_r_en=0, busy=0, done=0, underrun=0, len_err=0. Counters are cleared and the CRC register is set to 0xFFFFFFFF. A reset mid-frame drops gmii_tx_en on the next cycle, and no IFG is enforced.
- IDLE: on start=1, payload_len is checked. If it is 0 or greater than MAX_PAYLOAD, len_err pulses and the block stays in IDLE. Otherwise payload_len is latched, busy rises next cycle, and the FSM moves to PRE. start is ignored while busy=1.
- PRE: 7 cycles of 0x55. gmii_tx_en is high from the first PRE cycle, which is the cycle after start acceptance.
- SFD: 1 cycle of 0xD5.
- DST: 6 bytes. SRC: 6 bytes. LEN: 2 bytes, latched payload_len big-endian, zero-extended to 16 bits.
- FIFO prefetch: fifo_r_en is asserted in the last LEN cycle and in every PAY cycle except the last, so that fifo_data feeds gmii_txd in the following cycle.
  - fifo_r_en is asserted only when fifo_empty=0.
  - If a read is required while fifo_empty=1: fifo_r_en stays 0. The next cycle drives gmii_txd=0, gmii_tx_en=1, gmii_tx_er=1, and pulses underrun. The FSM then enters IFG with no FCS and no done.
- PAY: payload_len cycles, gmii_txd=fifo_data.
- PAD: max(0, MIN_PAYLOAD-payload_len) cycles of 0x00. No FIFO reads occur in PAD.
- FCS: 4 cycles carrying ~crc, least-significant byte first.
  - CRC-32 uses reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte.
  - It is computed over DST through PAD inclusive, and updated in the same cycle each byte is driven.
- IFG: gmii_tx_en=0 for IFG_CYCLES cycles. done pulses in the first IFG cycle after a clean frame. busy falls after the last IFG cycle, and the FSM returns to IDLE. A start on the first IDLE cycle is accepted.
- Frame length on the wire (gmii_tx_en high): 8+14+max(payload_len,46)+4 cycles.
- Counters: one 11-bit byte counter reused per state. No wrap is reachable within legal lengths.

Optional Feature:
TX_FCS_EN:
- Defined: the CRC-32 generator and FCS state are present, as described above.
- Undefined: no CRC logic is built and the FSM goes from PAY/PAD directly to IFG. Frame length on the wire is 4 bytes shorter. done pulses in the first IFG cycle as before.

Test Plan:
- Reset, then idle for 20 cycles -> all outputs 0 and fifo_r_en never asserted.
- start with payload_len=60, FIFO preloaded with bytes 0x00..0x3B -> wire frame is 55×7, D5, 02 35 28 FB DD 66 twice, 00 3C, payload 00..3B, then 4 FCS bytes equal to the zlib crc32 of bytes 8..81. gmii_tx_en is high for 86 cycles, then low for 12 cycles; done pulses once.
- payload_len=10 -> 10 payload bytes, 36 bytes of 0x00, valid FCS, gmii_tx_en high for 72 cycles, exactly 10 fifo_r_en pulses.
- payload_len=20 with only 5 bytes in the FIFO -> after payload byte 5, one cycle with gmii_tx_er=1, underrun pulses, gmii_tx_en drops, no done, busy clears after 12 IFG cycles.
- start with payload_len=0, then with 1501 -> len_err pulses each time, busy stays 0. start with 1500 -> accepted.
- eth_rst asserted mid-PAY -> gmii_tx_en=0 next cycle, busy=0. The following start with payload_len=46 transmits a correct 72-byte frame.
